// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam int REG_AW_DEF      = 5;
  localparam int CNT_W_DEF       = 16;
  localparam int MEM_TIMEOUT_DEF = 64;
  localparam int REG_ZERO        = 0;

endpackage

// File: rtl/raw_compare.sv
// Read-after-write match of one in-flight writer against the ID-stage sources.
module raw_compare
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] rd_i,
  input  logic              regwrite_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rt_i,
  input  logic              uses_rt_i,
  output logic              hit_o
);

  logic rd_nonzero;

  // Register 0 is hardwired, so writes to it never produce a dependency.
  assign rd_nonzero = (rd_i != REG_AW'(REG_ZERO));
  assign hit_o      = regwrite_i && rd_nonzero &&
                      ((rd_i == rs_i) || (uses_rt_i && (rd_i == rt_i)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register sequencer: memory freeze, branch flush and data-hazard stall.
// Build option PIPE_FORWARD_EN: forwarding present, only load-use stalls remain.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memtoreg,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic              mem_access,
  input  logic              mem_ready,
  input  logic              mem_br_taken,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              exmem_en,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              exmem_flush,
  output logic              memwb_bubble,
  output logic              pc_sel_branch,
  output logic [CNT_W-1:0]  stall_count,
  output logic              mem_timeout_err
);

  localparam int WAIT_W = 16;

`ifdef PIPE_FORWARD_EN
  localparam logic FORWARD = 1'b1;
`else
  localparam logic FORWARD = 1'b0;
`endif

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_count_q, stall_count_d;
  logic               timeout_err_q, timeout_err_d;

  logic freeze;
  logic ex_wr_qual;
  logic ex_hit;
  logic data_hazard;

  assign freeze = mem_access && !mem_ready;

  // With forwarding only a load in EX is too late to bypass.
  assign ex_wr_qual = ex_regwrite && (ex_memtoreg || !FORWARD);

  raw_compare #(.REG_AW(REG_AW)) u_ex_cmp (
    .rd_i       (ex_rd),
    .regwrite_i (ex_wr_qual),
    .rs_i       (id_rs),
    .rt_i       (id_rt),
    .uses_rt_i  (id_uses_rt),
    .hit_o      (ex_hit)
  );

`ifdef PIPE_FORWARD_EN
  assign data_hazard = ex_hit;
`else
  logic mem_hit;

  raw_compare #(.REG_AW(REG_AW)) u_mem_cmp (
    .rd_i       (mem_rd),
    .regwrite_i (mem_regwrite),
    .rs_i       (id_rs),
    .rt_i       (id_rt),
    .uses_rt_i  (id_uses_rt),
    .hit_o      (mem_hit)
  );

  assign data_hazard = ex_hit || mem_hit;
`endif

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    stall_count_d = stall_count_q;
    pc_en         = 1'b1;
    ifid_en       = 1'b1;
    idex_en       = 1'b1;
    exmem_en      = 1'b1;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    exmem_flush   = 1'b0;
    memwb_bubble  = 1'b0;
    pc_sel_branch = 1'b0;

    unique case (state_q)
      RUN:      if (freeze)    state_d = MEM_WAIT;
      MEM_WAIT: if (mem_ready) state_d = RUN;
      default:                 state_d = RUN;
    endcase

    if (state_d == RUN) begin
      wait_cnt_d = '0;
    end else if (freeze && (wait_cnt_q < WAIT_W'(MEM_TIMEOUT))) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
    if (wait_cnt_d == WAIT_W'(MEM_TIMEOUT)) timeout_err_d = 1'b1;

    // Release cycle falls straight through to normal evaluation.
    if (reset) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_flush  = 1'b1;
      memwb_bubble = 1'b1;
    end else if (freeze) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (mem_br_taken) begin
      pc_sel_branch = 1'b1;
      ifid_flush    = 1'b1;
      idex_bubble   = 1'b1;
      exmem_flush   = 1'b1;
    end else if (data_hazard) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end

    if (!pc_en && (stall_count_q != '1)) stall_count_d = stall_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      stall_count_q <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_count_q <= stall_count_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign stall_count     = stall_count_q;
  assign mem_timeout_err = timeout_err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl; honours PIPE_FORWARD_EN like the DUT.
module tb_pipeline_hazard_ctrl;

  localparam int REG_AW      = 5;
  localparam int CNT_W       = 5;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

`ifdef PIPE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble, exmem_flush, memwb_bubble, pc_sel_branch}
  localparam logic [8:0] C_RESET  = 9'b0000_1111_0;
  localparam logic [8:0] C_FREEZE = 9'b0000_0001_0;
  localparam logic [8:0] C_BRANCH = 9'b1111_1110_1;
  localparam logic [8:0] C_STALL  = 9'b0011_0100_0;
  localparam logic [8:0] C_RUN    = 9'b1111_0000_0;

  logic clk = 1'b0;
  logic reset;
  logic [REG_AW-1:0] id_rs, id_rt, ex_rd, mem_rd;
  logic id_uses_rt, ex_regwrite, ex_memtoreg, mem_regwrite;
  logic mem_access, mem_ready, mem_br_taken;
  logic pc_en, ifid_en, idex_en, exmem_en;
  logic ifid_flush, idex_bubble, exmem_flush, memwb_bubble, pc_sel_branch;
  logic [CNT_W-1:0] stall_count;
  logic mem_timeout_err;
  logic [8:0] ctl;

  int n_cmp = 0;
  int n_bad = 0;
  int m_stall = 0;
  int m_wait = 0;
  bit m_err = 1'b0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .REG_AW(REG_AW), .CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .mem_access(mem_access), .mem_ready(mem_ready), .mem_br_taken(mem_br_taken),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .exmem_flush(exmem_flush),
    .memwb_bubble(memwb_bubble), .pc_sel_branch(pc_sel_branch),
    .stall_count(stall_count), .mem_timeout_err(mem_timeout_err)
  );

  assign ctl = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble,
                exmem_flush, memwb_bubble, pc_sel_branch};

  // Does a writer (w, rd) produce a value the ID instruction reads?
  function automatic bit dep(input logic w, input logic [REG_AW-1:0] rd);
    return w && (rd != 0) && ((rd == id_rs) || (id_uses_rt && (rd == id_rt)));
  endfunction

  function automatic logic [8:0] model_ctl();
    bit haz;
    if (FWD) haz = dep(ex_regwrite && ex_memtoreg, ex_rd);
    else     haz = dep(ex_regwrite, ex_rd) || dep(mem_regwrite, mem_rd);
    if (reset)                     return C_RESET;
    if (mem_access && !mem_ready)  return C_FREEZE;
    if (mem_br_taken)              return C_BRANCH;
    if (haz)                       return C_STALL;
    return C_RUN;
  endfunction

  task automatic settle();
    #1;
  endtask

  // Advance the reference state with the inputs of this cycle, then move to the next cycle.
  task automatic tick();
    logic [8:0] e;
    e = model_ctl();
    if (reset) begin
      m_stall = 0;
      m_wait  = 0;
      m_err   = 1'b0;
    end else begin
      if (!e[8] && m_stall < CNT_MAX) m_stall++;
      if (mem_access && !mem_ready) begin
        m_wait++;
        if (m_wait >= MEM_TIMEOUT) m_err = 1'b1;
      end else begin
        m_wait = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
    ex_rd = '0; ex_regwrite = 1'b0; ex_memtoreg = 1'b0;
    mem_rd = '0; mem_regwrite = 1'b0;
    mem_access = 1'b0; mem_ready = 1'b1; mem_br_taken = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    settle();
    n_cmp++;
    if (ctl !== C_RESET) begin n_bad++; $display("FAIL reset_ctl got %b exp %b", ctl, C_RESET); end
    tick();
    tick();
    n_cmp++;
    if (stall_count !== '0) begin n_bad++; $display("FAIL reset_stall got %0d exp 0", stall_count); end
    n_cmp++;
    if (mem_timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b exp 0", mem_timeout_err); end
    reset = 1'b0;
    settle();
    n_cmp++;
    if (ctl !== C_RUN) begin n_bad++; $display("FAIL reset_release_ctl got %b exp %b", ctl, C_RUN); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_memtoreg = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
    settle();
    n_cmp++;
    if (ctl !== C_STALL) begin n_bad++; $display("FAIL loaduse_ctl got %b exp %b", ctl, C_STALL); end
    tick();
    n_cmp++;
    if (stall_count !== 5'd1) begin n_bad++; $display("FAIL loaduse_cnt got %0d exp 1", stall_count); end
    // Bubble now in EX, load in MEM.
    ex_memtoreg = 1'b0; ex_regwrite = 1'b0; ex_rd = '0;
    mem_rd = 5'd8; mem_regwrite = 1'b1;
    settle();
    n_cmp++;
    if (ctl !== (FWD ? C_RUN : C_STALL)) begin
      n_bad++; $display("FAIL loaduse_next_ctl got %b exp %b", ctl, FWD ? C_RUN : C_STALL);
    end
    tick();
    mem_regwrite = 1'b0; mem_rd = '0;
    settle();
    n_cmp++;
    if (ctl !== C_RUN) begin n_bad++; $display("FAIL loaduse_after_ctl got %b exp %b", ctl, C_RUN); end
    n_cmp++;
    if (stall_count !== (FWD ? 5'd1 : 5'd2)) begin
      n_bad++; $display("FAIL loaduse_total got %0d exp %0d", stall_count, FWD ? 1 : 2);
    end
    tick();
  endtask

  task automatic test_zero_reg();
    do_reset();
    ex_memtoreg = 1'b1; ex_regwrite = 1'b1; ex_rd = '0; id_rs = '0;
    mem_regwrite = 1'b1; mem_rd = '0; id_uses_rt = 1'b1; id_rt = '0;
    settle();
    n_cmp++;
    if (ctl !== C_RUN) begin n_bad++; $display("FAIL zero_reg_ctl got %b exp %b", ctl, C_RUN); end
    tick();
    n_cmp++;
    if (stall_count !== '0) begin n_bad++; $display("FAIL zero_reg_cnt got %0d exp 0", stall_count); end
  endtask

  task automatic test_branch_vs_hazard();
    do_reset();
    ex_memtoreg = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
    mem_br_taken = 1'b1;
    settle();
    n_cmp++;
    if (ctl !== C_BRANCH) begin n_bad++; $display("FAIL branch_ctl got %b exp %b", ctl, C_BRANCH); end
    tick();
    n_cmp++;
    if (stall_count !== '0) begin n_bad++; $display("FAIL branch_cnt got %0d exp 0", stall_count); end
  endtask

  task automatic test_mem_freeze_branch();
    do_reset();
    mem_access = 1'b1; mem_ready = 1'b0; mem_br_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_cmp++;
      if (ctl !== C_FREEZE) begin n_bad++; $display("FAIL freeze_ctl[%0d] got %b exp %b", i, ctl, C_FREEZE); end
      tick();
    end
    mem_ready = 1'b1;
    settle();
    n_cmp++;
    if (ctl !== C_BRANCH) begin n_bad++; $display("FAIL freeze_release_ctl got %b exp %b", ctl, C_BRANCH); end
    n_cmp++;
    if (stall_count !== 5'd3) begin n_bad++; $display("FAIL freeze_cnt got %0d exp 3", stall_count); end
    tick();
    n_cmp++;
    if (stall_count !== 5'd3) begin n_bad++; $display("FAIL freeze_cnt_after got %0d exp 3", stall_count); end
  endtask

  task automatic test_timeout();
    do_reset();
    mem_access = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      settle();
      n_cmp++;
      if (mem_timeout_err !== (i >= MEM_TIMEOUT)) begin
        n_bad++; $display("FAIL timeout_err[%0d] got %b exp %b", i, mem_timeout_err, i >= MEM_TIMEOUT);
      end
      tick();
    end
    mem_ready = 1'b1;
    tick();
    mem_access = 1'b0;
    settle();
    n_cmp++;
    if (mem_timeout_err !== 1'b1) begin n_bad++; $display("FAIL timeout_sticky got %b exp 1", mem_timeout_err); end
    mem_access = 1'b1; mem_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    settle();
    n_cmp++;
    if (ctl !== C_RESET) begin n_bad++; $display("FAIL timeout_rst_ctl got %b exp %b", ctl, C_RESET); end
    tick();
    reset = 1'b0; mem_access = 1'b0; mem_ready = 1'b1;
    settle();
    n_cmp++;
    if (mem_timeout_err !== 1'b0) begin n_bad++; $display("FAIL timeout_rst_err got %b exp 0", mem_timeout_err); end
    n_cmp++;
    if (ctl !== C_RUN) begin n_bad++; $display("FAIL timeout_rst_run got %b exp %b", ctl, C_RUN); end
    tick();
    // A fresh wait must start counting from zero again.
    mem_access = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      n_cmp++;
      if (mem_timeout_err !== (i >= MEM_TIMEOUT)) begin
        n_bad++; $display("FAIL timeout_rewait_err[%0d] got %b exp %b", i, mem_timeout_err, i >= MEM_TIMEOUT);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_stall_saturation();
    do_reset();
    mem_access = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < CNT_MAX + 6; i++) begin
      settle();
      n_cmp++;
      if (stall_count !== CNT_W'((i < CNT_MAX) ? i : CNT_MAX)) begin
        n_bad++; $display("FAIL stall_sat[%0d] got %0d exp %0d", i, stall_count, (i < CNT_MAX) ? i : CNT_MAX);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_alu_dependency();
    int stalls;
    do_reset();
    stalls = 0;
    id_rt = 5'd5; id_uses_rt = 1'b1; id_rs = 5'd1;
    for (int c = 0; c < 3; c++) begin
      ex_regwrite  = (c == 0); ex_rd  = (c == 0) ? 5'd5 : 5'd0;
      mem_regwrite = (c == 1); mem_rd = (c == 1) ? 5'd5 : 5'd0;
      settle();
      if (!pc_en) stalls++;
      tick();
    end
    n_cmp++;
    if (stalls !== (FWD ? 0 : 2)) begin n_bad++; $display("FAIL alu_dep_stalls got %0d exp %0d", stalls, FWD ? 0 : 2); end
    n_cmp++;
    if (stall_count !== (FWD ? 5'd0 : 5'd2)) begin
      n_bad++; $display("FAIL alu_dep_cnt got %0d exp %0d", stall_count, FWD ? 0 : 2);
    end
    // Writer matches rt, but the instruction does not read rt.
    id_uses_rt = 1'b0; ex_regwrite = 1'b1; ex_rd = 5'd5; mem_regwrite = 1'b0;
    settle();
    n_cmp++;
    if (ctl !== C_RUN) begin n_bad++; $display("FAIL alu_no_rt_ctl got %b exp %b", ctl, C_RUN); end
    tick();
  endtask

  task automatic test_random();
    logic [8:0] e;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      id_rs        = REG_AW'($urandom_range(0, 3));
      id_rt        = REG_AW'($urandom_range(0, 3));
      id_uses_rt   = 1'($urandom_range(0, 1));
      ex_rd        = REG_AW'($urandom_range(0, 3));
      ex_regwrite  = 1'($urandom_range(0, 1));
      ex_memtoreg  = 1'($urandom_range(0, 1));
      mem_rd       = REG_AW'($urandom_range(0, 3));
      mem_regwrite = 1'($urandom_range(0, 1));
      mem_access   = (m_wait > 0) || ($urandom_range(0, 2) == 0);
      mem_ready    = ($urandom_range(0, 2) == 0);
      mem_br_taken = ($urandom_range(0, 3) == 0);
      reset        = ($urandom_range(0, 59) == 0);
      settle();
      e = model_ctl();
      n_cmp++;
      if (ctl !== e) begin n_bad++; $display("FAIL rand_ctl[%0d] got %b exp %b", i, ctl, e); end
      n_cmp++;
      if (stall_count !== CNT_W'(m_stall)) begin
        n_bad++; $display("FAIL rand_cnt[%0d] got %0d exp %0d", i, stall_count, m_stall);
      end
      n_cmp++;
      if (mem_timeout_err !== m_err) begin
        n_bad++; $display("FAIL rand_err[%0d] got %b exp %b", i, mem_timeout_err, m_err);
      end
      tick();
    end
    reset = 1'b0;
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch_vs_hazard();
    test_mem_freeze_branch();
    test_timeout();
    test_stall_saturation();
    test_alu_dependency();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the 5-stage pipeline registers (PC, IF/ID, ID/EX control and data, EX/MEM, MEM/WB).
- Detects data hazards, taken branches and slow data-memory accesses.
- Drives the enable, bubble and flush inputs of every pipeline register, so the control flops load zeros or hold as required.
- Keeps a saturating stall-cycle counter and a sticky memory-timeout flag for debug.

Parameters:
REG_AW, 5, register-specifier width
CNT_W, 16, stall counter width
MEM_TIMEOUT, 64, consecutive wait cycles before mem_timeout_err sets (1..2^16-1)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
id_rs  in  REG_AW  source reg of instruction in ID
id_rt  in  REG_AW  second source reg in ID
id_uses_rt  in  1  ID instruction reads rt
ex_rd  in  REG_AW  destination reg of EX instruction
ex_regwrite  in  1  EX instruction writes a register
ex_memtoreg  in  1  EX instruction is a load
mem_rd  in  REG_AW  destination reg of MEM instruction
mem_regwrite  in  1  MEM instruction writes a register
mem_access  in  1  MEM instruction is a load or store
mem_ready  in  1  data memory completes the access this cycle
mem_br_taken  in  1  branch resolved taken in MEM
pc_en, ifid_en, idex_en, exmem_en  out  1 each  pipeline register load enables
ifid_flush, idex_bubble, exmem_flush, memwb_bubble  out  1 each  load zeros (NOP, all controls 0)
pc_sel_branch  out  1  PC loads branch target
stall_count  out  CNT_W  cycles with pc_en=0 since reset, saturating
mem_timeout_err  out  1  sticky: a memory wait reached MEM_TIMEOUT

Behaviour:
Reset:
- One clock, one reset: clk rising edge; reset is synchronous and active-high.
- While reset=1: state=RUN, wait_cnt=0, stall_count=0, mem_timeout_err=0.
- All enables=0, all flush/bubble=1, pc_sel_branch=0.

Control outputs:
- Outputs are combinational from inputs plus state, effective on the same edge.
- Registered state: FSM, wait_cnt, stall_count, mem_timeout_err.

FSM states:
- RUN to MEM_WAIT when mem_access=1 and mem_ready=0.
- MEM_WAIT back to RUN in the cycle mem_ready=1.

Priority, highest first: reset > memory freeze > branch flush > data stall. Default is all enables=1, all flush/bubble=0.
- Memory freeze: when mem_access=1 and mem_ready=0, in either state.
  - pc_en, ifid_en, idex_en, exmem_en=0; memwb_bubble=1.
  - Branch and data-hazard logic are ignored.
  - The MEM/EX/ID contents are frozen, so a pending branch or hazard re-evaluates on the release cycle.
- Release cycle: mem_ready=1. Normal evaluation applies in that same cycle (zero-cycle exit).
- Branch flush: when mem_br_taken=1.
  - pc_sel_branch=1; ifid_flush, idex_bubble, exmem_flush=1.
  - The data-hazard stall is suppressed, because the ID instruction is squashed.
- Load-use stall: when ex_memtoreg and ex_regwrite are 1, ex_rd!=0, and either ex_rd==id_rs, or ex_rd==id_rt with id_uses_rt=1.
  - pc_en=0, ifid_en=0, idex_bubble=1. EX/MEM and MEM/WB advance.
  - Lasts exactly 1 cycle, because the load moves to MEM.
- Register 0 never creates a hazard.
- wait_cnt: cleared on entry to RUN, increments each MEM_WAIT cycle, saturates at MEM_TIMEOUT. When it reaches MEM_TIMEOUT, mem_timeout_err=1 until reset. The pipeline keeps waiting.
- stall_count: +1 on every non-reset cycle with pc_en=0, covering both freeze and stall. Holds at 2^CNT_W-1.

Optional Feature:
PIPE_FORWARD_EN
- Defined: forwarding unit present; only the load-use stall above applies.
- Undefined: no forwarding. Stall (pc_en=0, ifid_en=0, idex_bubble=1) whenever the ID sources match a nonzero writer in EX (any ex_regwrite) or MEM (mem_regwrite).
  - A dependent instruction stalls up to 2 cycles.
  - The WB writer is not a hazard, because the regfile writes before it reads.

Decomposition:
- Package hazard_pkg:
  - state enum {RUN, MEM_WAIT}
  - REG_ZERO constant
  - default CNT_W and MEM_TIMEOUT
- Sub-module raw_compare: combinational match of one writer (rd, regwrite) against id_rs, id_rt and id_uses_rt, with the zero-register exclusion.
  - Instantiated once for EX, plus once for MEM when PIPE_FORWARD_EN is undefined.

Test Plan:
- Load-use: ex_memtoreg=1, ex_regwrite=1, ex_rd=8, id_rs=8 -> exactly 1 cycle with pc_en=0, ifid_en=0, idex_bubble=1; stall_count 0->1; next cycle all enables 1.
- Zero register: same as load-use but ex_rd=0, id_rs=0 -> no stall, all enables 1.
- Branch vs hazard: mem_br_taken=1 together with a load-use match -> pc_sel_branch=1, ifid_flush/idex_bubble/exmem_flush=1, pc_en=1, stall_count unchanged.
- Memory freeze with pending branch:
  - Stimulus: mem_access=1, mem_ready=0 for 3 cycles while mem_br_taken=1.
  - During wait: 3 freeze cycles, memwb_bubble=1, pc_sel_branch=0.
  - Release cycle: pc_sel_branch=1; stall_count=3.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> mem_timeout_err rises after the 4th wait cycle and stays 1 after mem_ready=1. Reset in mid-wait -> error=0, state=RUN, outputs at reset values.
- Without PIPE_FORWARD_EN: ex_regwrite=1, ex_rd=5, id_rt=5, id_uses_rt=1 (ALU op) -> 2 stall cycles as the writer moves EX->MEM->WB. With the macro defined -> 0 stall cycles.
